tti_tx_byte_sequencer: RTL and testbench
========================================

# tti_tx_byte_sequencer

Transfer-level controller for the TTI TX path. It sits between the TX descriptor queue, the TX data queue, the N-to-8 width converter and the I3C target FSM. It takes one descriptor (a byte length) at a time, admits exactly ceil(len/Bytes) data words into the converter, and forwards exactly len bytes to the target FSM with a last flag. It flushes the converter's residual bytes at end of transfer or on a bus abort.

## Interface
- Width, 32: data queue / converter word width; must be a multiple of 8. Bytes = Width/8.
- LenWidth, 16: width of the descriptor byte-length field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- desc_valid_i  in  1  descriptor available
- desc_ready_o  out  1  descriptor accepted
- desc_len_i  in  LenWidth  transfer length in bytes
- data_valid_i  in  1  TX data queue word available
- data_ready_o  out  1  TX data queue pop
- data_i  in  Width  TX data word, little-endian byte order
- conv_sink_valid_o  out  1  word valid to converter
- conv_sink_ready_i  in  1  converter accepts word
- conv_sink_data_o  out  Width  word to converter; equals data_i
- conv_source_valid_i  in  1  converter byte valid
- conv_source_ready_o  out  1  byte taken from converter
- conv_source_data_i  in  8  converter byte
- conv_flush_o  out  1  discard the converter's remaining bytes
- byte_valid_o  out  1  byte to target FSM valid
- byte_ready_i  in  1  target FSM accepts byte
- byte_data_o  out  8  byte to target FSM; equals conv_source_data_i
- byte_last_o  out  1  current byte is the final byte of the transfer
- abort_i  in  1  bus-side termination (NACK/STOP); single-cycle pulse
- done_o  out  1  one-cycle pulse at end of transfer
- aborted_o  out  1  qualified by done_o; the transfer was aborted
- busy_o  out  1  FSM not in IDLE

## Operation
- Registers:
  - state
  - bytes_left[LenWidth-1:0]
  - words_left[LenWidth-1:0], loaded with (len + Bytes-1) / Bytes
  - abort_flag
- IDLE:
  - desc_ready_o = 1.
  - On desc handshake, load the counters.
  - If len==0, go to DONE; otherwise go to STREAM.
  - abort_i is ignored.
- STREAM:
  - Word side:
    - conv_sink_valid_o = data_valid_i & (words_left!=0).
    - data_ready_o = conv_sink_ready_i & (words_left!=0).
    - words_left decrements on each word handshake.
  - Byte side:
    - byte_valid_o = conv_source_valid_i & ~abort_i.
    - conv_source_ready_o = byte_ready_i & ~abort_i.
    - byte_last_o = (bytes_left==1).
    - bytes_left decrements on each byte handshake.
  - On the last-byte handshake: conv_flush_o = 1 in the same cycle, then go to DONE.
  - On abort_i: conv_flush_o = 1, abort_flag is set, no byte handshake occurs that cycle, then go to DRAIN (see Configuration) or DONE.
  - Abort wins over a simultaneous last byte. That byte is not delivered and aborted_o = 1.
- DRAIN:
  - data_ready_o = 1; conv_sink_valid_o = 0.
  - Each data_valid_i pops a word and decrements words_left.
  - When words_left==0, go to DONE.
- DONE:
  - done_o = 1 and aborted_o = abort_flag.
  - Clear abort_flag and go to IDLE.
- All outputs are combinational from state, the registered counters and the handshake inputs. There is no combinational path from desc_valid_i to any output.
- Arithmetic:
  - The words_left computation is done at LenWidth+1 bits to avoid overflow at len = 2^LenWidth-1.
  - Counters never decrement below 0; a handshake with the counter at 0 is impossible by gating.

## Timing
- Reset values:
  - state=IDLE; counters=0.
  - desc_ready_o=1.
  - All other outputs are 0.
- Latency:
  - Descriptor accepted in cycle T; the first word is offered to the converter in T+1.
  - The first byte reaches byte_valid_o in T+2, given data_valid_i is high at T+1.
- len==0: done_o fires at T+1. desc_ready_o is high again at T+2.
- Back-to-back transfers: minimum gap is 2 cycles (DONE, then IDLE) between the last byte and the next descriptor acceptance.
- Reset asserted mid-transfer: returns to reset values immediately. Partially consumed queue contents are not restored.

## Configuration
- Macro I3C_TX_SEQ_DRAIN_EN.
- Defined: an abort with words_left!=0 enters DRAIN. The queue is left aligned to the next transfer.
- Undefined: an abort goes directly to DONE, the DRAIN state is not built, and unread words remain in the TX data queue. Software must reset the queue.

## Test plan
All scenarios use Width=32.
- len=5, words 0x44332211 and 0x88776655:
  - Bytes 11,22,33,44,55 are delivered; byte_last_o is high only with 55.
  - conv_flush_o pulses with 55, and bytes 66..88 never appear.
  - done_o then aborted_o=0.
- len=0: descriptor consumed; data_ready_o stays 0; done_o pulses 1 cycle after acceptance.
- len=8, byte_ready_i toggling 1/0 every cycle: 8 bytes 11..88 delivered in order, held stable while stalled; last flag on 88.
- len=12, abort_i after 2nd byte:
  - conv_flush_o pulses in the abort cycle.
  - With DRAIN_EN, the remaining 2 words are popped and done_o/aborted_o=1 follow.
  - Without DRAIN_EN, done_o arrives the next cycle and 2 words remain in the queue.
- Two descriptors len=4 and len=3 queued: 7 bytes delivered, last on the 4th and the 7th, two done_o pulses.
- rst_ni pulsed low after the 3rd byte of len=8: all outputs return to reset values and the next len=4 transfer completes normally.

Source files
------------

// File: rtl/tti_tx_byte_sequencer.sv
// TTI TX transfer sequencer: admits ceil(len/Bytes) words into the N-to-8 converter and forwards len bytes with a last flag.
// Optional feature macro: I3C_TX_SEQ_DRAIN_EN (builds the DRAIN state that empties the data queue after an abort).
module tti_tx_byte_sequencer #(
    parameter int Width    = 32,
    parameter int LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    input  logic [LenWidth-1:0] desc_len_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic [Width-1:0]    data_i,
    output logic                conv_sink_valid_o,
    input  logic                conv_sink_ready_i,
    output logic [Width-1:0]    conv_sink_data_o,
    input  logic                conv_source_valid_i,
    output logic                conv_source_ready_o,
    input  logic [7:0]          conv_source_data_i,
    output logic                conv_flush_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic [7:0]          byte_data_o,
    output logic                byte_last_o,
    input  logic                abort_i,
    output logic                done_o,
    output logic                aborted_o,
    output logic                busy_o
);
    localparam int Bytes = Width / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
`ifdef I3C_TX_SEQ_DRAIN_EN
        ST_DRAIN  = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [LenWidth-1:0] r_bytes_left;
    logic [LenWidth-1:0] w_bytes_next;
    logic [LenWidth-1:0] r_words_left;
    logic [LenWidth-1:0] w_words_next;
    logic [LenWidth-1:0] w_words_load;
    logic                r_abort_flag;
    logic                w_abort_next;
    logic                w_words_nz;
    logic                w_word_hs;
    logic                w_byte_hs;

    // One extra bit so the rounding add cannot wrap at the maximum length.
    assign w_words_load = LenWidth'(({1'b0, desc_len_i} + (LenWidth+1)'(Bytes - 1))
                                    / (LenWidth+1)'(Bytes));

    assign w_words_nz       = (r_words_left != '0);
    assign w_word_hs        = data_valid_i & conv_sink_ready_i & w_words_nz;
    assign w_byte_hs        = conv_source_valid_i & byte_ready_i & ~abort_i;
    assign conv_sink_data_o = data_i;
    assign byte_data_o      = conv_source_data_i;
    assign busy_o           = (r_state != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_bytes_left <= '0;
            r_words_left <= '0;
            r_abort_flag <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bytes_left <= w_bytes_next;
            r_words_left <= w_words_next;
            r_abort_flag <= w_abort_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_bytes_next        = r_bytes_left;
        w_words_next        = r_words_left;
        w_abort_next        = r_abort_flag;
        desc_ready_o        = 1'b0;
        data_ready_o        = 1'b0;
        conv_sink_valid_o   = 1'b0;
        conv_source_ready_o = 1'b0;
        conv_flush_o        = 1'b0;
        byte_valid_o        = 1'b0;
        byte_last_o         = 1'b0;
        done_o              = 1'b0;
        aborted_o           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    w_bytes_next = desc_len_i;
                    w_words_next = w_words_load;
                    w_state_next = (desc_len_i == '0) ? ST_DONE : ST_STREAM;
                end
            end

            ST_STREAM: begin
                conv_sink_valid_o   = data_valid_i & w_words_nz;
                data_ready_o        = conv_sink_ready_i & w_words_nz;
                byte_valid_o        = conv_source_valid_i & ~abort_i;
                conv_source_ready_o = byte_ready_i & ~abort_i;
                byte_last_o         = (r_bytes_left == LenWidth'(1));
                if (w_word_hs) begin
                    w_words_next = r_words_left - LenWidth'(1);
                end
                // Abort suppresses the byte handshake, so it beats a coincident last byte.
                if (abort_i) begin
                    conv_flush_o = 1'b1;
                    w_abort_next = 1'b1;
                    w_state_next = ST_DONE;
`ifdef I3C_TX_SEQ_DRAIN_EN
                    if (w_words_next != '0) begin
                        w_state_next = ST_DRAIN;
                    end
`endif
                end else if (w_byte_hs) begin
                    w_bytes_next = r_bytes_left - LenWidth'(1);
                    if (r_bytes_left == LenWidth'(1)) begin
                        conv_flush_o = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end

`ifdef I3C_TX_SEQ_DRAIN_EN
            ST_DRAIN: begin
                data_ready_o = w_words_nz;
                if (data_valid_i && w_words_nz) begin
                    w_words_next = r_words_left - LenWidth'(1);
                end
                if (w_words_next == '0) begin
                    w_state_next = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                done_o       = 1'b1;
                aborted_o    = r_abort_flag;
                w_abort_next = 1'b0;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tti_tx_byte_sequencer.sv
// Scoreboard bench for tti_tx_byte_sequencer with a data-queue model and a simple 32-to-8 converter model.
module tb_tti_tx_byte_sequencer;
    localparam int Width    = 32;
    localparam int LenWidth = 16;

    logic                clk = 1'b0;
    logic                rstN;
    logic                descValid;
    logic                descReady;
    logic [LenWidth-1:0] descLen;
    logic                dataValid;
    logic                dataReady;
    logic [Width-1:0]    dataIn;
    logic                sinkValid;
    logic                sinkReady;
    logic [Width-1:0]    sinkData;
    logic                srcValid;
    logic                srcReady;
    logic [7:0]          srcData;
    logic                convFlush;
    logic                byteValid;
    logic                byteReady;
    logic [7:0]          byteData;
    logic                byteLast;
    logic                abortIn;
    logic                done;
    logic                aborted;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int byteCount = 0;
    int doneCount = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } expByte_t;
    expByte_t expQ[$];
    logic     expDoneQ[$];

    always #5 clk = ~clk;

    tti_tx_byte_sequencer #(.Width(Width), .LenWidth(LenWidth)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .desc_valid_i(descValid), .desc_ready_o(descReady), .desc_len_i(descLen),
        .data_valid_i(dataValid), .data_ready_o(dataReady), .data_i(dataIn),
        .conv_sink_valid_o(sinkValid), .conv_sink_ready_i(sinkReady), .conv_sink_data_o(sinkData),
        .conv_source_valid_i(srcValid), .conv_source_ready_o(srcReady), .conv_source_data_i(srcData),
        .conv_flush_o(convFlush),
        .byte_valid_o(byteValid), .byte_ready_i(byteReady), .byte_data_o(byteData), .byte_last_o(byteLast),
        .abort_i(abortIn), .done_o(done), .aborted_o(aborted), .busy_o(busy)
    );

    // TX data queue model: written by the stimulus, popped on the DUT handshake.
    logic [31:0] dataMem [0:63];
    int          wrPtr = 0;
    int          rdPtr = 0;
    logic        qClear = 1'b0;
    assign dataValid = (rdPtr != wrPtr);
    assign dataIn    = dataMem[rdPtr[5:0]];

    always @(posedge clk) begin
        if (qClear) rdPtr <= wrPtr;
        else if (dataValid && dataReady) rdPtr <= rdPtr + 1;
    end

    // Converter model: accepts a word only when empty, emits LSB first, flush empties it.
    logic [31:0] convBuf = '0;
    int          convCnt = 0;
    assign sinkReady = (convCnt == 0);
    assign srcValid  = (convCnt != 0);
    assign srcData   = convBuf[7:0];

    always @(posedge clk or negedge rstN) begin
        if (!rstN) convCnt <= 0;
        else if (convFlush) convCnt <= 0;
        else if (srcValid && srcReady) begin
            convBuf <= convBuf >> 8;
            convCnt <= convCnt - 1;
        end else if (sinkValid && sinkReady) begin
            convBuf <= sinkData;
            convCnt <= 4;
        end
    end

    logic toggleMode = 1'b0;
    logic toggleBit  = 1'b0;
    always @(posedge clk) toggleBit <= ~toggleBit;
    assign byteReady = toggleMode ? toggleBit : 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge values are the ones the next edge commits.
    logic       stallSeen = 1'b0;
    logic [7:0] stallData = '0;
    always @(negedge clk) begin
        if (rstN) begin
            if (toggleMode && stallSeen) begin
                checkOutput("stallHoldValid", byteValid, 1);
                checkOutput("stallHoldData", byteData, stallData);
            end
            stallSeen = byteValid && !byteReady;
            stallData = byteData;
            if (byteValid && byteReady) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedByte actual=%0h required=none", byteData);
                end else begin
                    expByte_t e;
                    e = expQ.pop_front();
                    checkOutput("byteData", byteData, e.data);
                    checkOutput("byteLast", byteLast, e.last);
                    checkOutput("flushWithLast", convFlush, e.last);
                end
                byteCount++;
            end
            if (done) begin
                if (expDoneQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedDone actual=1 required=0");
                end else begin
                    checkOutput("aborted", aborted, expDoneQ.pop_front());
                end
                doneCount++;
            end
        end else begin
            stallSeen = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [31:0] w);
        dataMem[wrPtr[5:0]] = w;
        wrPtr++;
    endtask

    task automatic expectSeq(input logic [7:0] startByte, input logic [7:0] step, input int n, input bit markLast);
        logic [7:0] b;
        b = startByte;
        for (int i = 0; i < n; i++) begin
            expQ.push_back('{data: b, last: (markLast && i == n - 1)});
            b = b + step;
        end
    endtask

    // Presents a descriptor and returns one cycle after it is accepted.
    task automatic applyStimulus(input int len);
        int waitCnt;
        descValid = 1'b1;
        descLen   = LenWidth'(len);
        waitCnt   = 0;
        while (!descReady && waitCnt < 200) begin
            tick();
            waitCnt++;
        end
        if (!descReady) begin
            total++;
            bad++;
            $display("[TB] FAIL descAcceptTimeout actual=0 required=1");
        end
        tick();
        descValid = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int waitCnt;
        waitCnt = 0;
        while (doneCount < target && waitCnt < 300) begin
            tick();
            waitCnt++;
        end
        checkOutput("doneSeen", (doneCount >= target), 1);
    endtask

    task automatic waitBytes(input int target);
        int waitCnt;
        waitCnt = 0;
        while (byteCount < target && waitCnt < 300) begin
            tick();
            waitCnt++;
        end
        checkOutput("bytesSeen", (byteCount >= target), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rstN      = 1'b0;
        descValid = 1'b0;
        descLen   = '0;
        abortIn   = 1'b0;
        tick();
        checkOutput("rstDescReady", descReady, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstDataReady", dataReady, 0);
        checkOutput("rstByteValid", byteValid, 0);
        tick();
        rstN = 1'b1;
        tick();

        $display("[TB] len=5");
        pushWord(32'h4433_2211);
        pushWord(32'h8877_6655);
        expectSeq(8'h11, 8'h11, 5, 1);
        expDoneQ.push_back(1'b0);
        base = doneCount;
        applyStimulus(5);
        waitDone(base + 1);
        tick();
        checkOutput("len5QueueEmpty", wrPtr - rdPtr, 0);
        checkOutput("len5ScoreboardEmpty", expQ.size(), 0);

        $display("[TB] len=0");
        expDoneQ.push_back(1'b0);
        base = doneCount;
        applyStimulus(0);
        checkOutput("len0DoneAtT1", done, 1);
        checkOutput("len0DataReady", dataReady, 0);
        tick();
        checkOutput("len0DescReadyT2", descReady, 1);
        checkOutput("len0DoneCount", doneCount, base + 1);

        $display("[TB] len=8 stalled");
        toggleMode = 1'b1;
        pushWord(32'h4433_2211);
        pushWord(32'h8877_6655);
        expectSeq(8'h11, 8'h11, 8, 1);
        expDoneQ.push_back(1'b0);
        base = doneCount;
        applyStimulus(8);
        waitDone(base + 1);
        toggleMode = 1'b0;
        tick();
        checkOutput("len8ScoreboardEmpty", expQ.size(), 0);

        $display("[TB] len=12 abort");
        pushWord(32'h4433_2211);
        pushWord(32'h8877_6655);
        pushWord(32'hCCBB_AA99);
        expectSeq(8'h11, 8'h11, 2, 0);
        expDoneQ.push_back(1'b1);
        base = doneCount;
        applyStimulus(12);
        waitBytes(byteCount + 2);
        abortIn = 1'b1;
        #1;
        checkOutput("abortFlush", convFlush, 1);
        checkOutput("abortByteValid", byteValid, 0);
        checkOutput("abortSrcReady", srcReady, 0);
        tick();
        abortIn = 1'b0;
`ifndef I3C_TX_SEQ_DRAIN_EN
        checkOutput("abortDoneNext", done, 1);
`endif
        waitDone(base + 1);
        tick();
`ifdef I3C_TX_SEQ_DRAIN_EN
        checkOutput("abortWordsLeft", wrPtr - rdPtr, 0);
`else
        checkOutput("abortWordsLeft", wrPtr - rdPtr, 2);
`endif
        checkOutput("abortScoreboardEmpty", expQ.size(), 0);
        qClear = 1'b1;
        tick();
        qClear = 1'b0;

        $display("[TB] len=4 then len=3");
        pushWord(32'h4433_2211);
        pushWord(32'h00CC_BBAA);
        expectSeq(8'h11, 8'h11, 4, 1);
        expectSeq(8'hAA, 8'h11, 3, 1);
        expDoneQ.push_back(1'b0);
        expDoneQ.push_back(1'b0);
        base = doneCount;
        applyStimulus(4);
        applyStimulus(3);
        waitDone(base + 2);
        tick();
        checkOutput("b2bScoreboardEmpty", expQ.size(), 0);

        $display("[TB] reset mid-transfer");
        pushWord(32'h4433_2211);
        pushWord(32'h8877_6655);
        expectSeq(8'h11, 8'h11, 8, 1);
        expDoneQ.push_back(1'b0);
        applyStimulus(8);
        waitBytes(byteCount + 3);
        rstN = 1'b0;
        #1;
        checkOutput("midRstDescReady", descReady, 1);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDataReady", dataReady, 0);
        checkOutput("midRstSinkValid", sinkValid, 0);
        checkOutput("midRstByteValid", byteValid, 0);
        checkOutput("midRstByteLast", byteLast, 0);
        checkOutput("midRstFlush", convFlush, 0);
        checkOutput("midRstDone", done, 0);
        expQ.delete();
        expDoneQ.delete();
        qClear = 1'b1;
        tick();
        qClear = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        pushWord(32'h4433_2211);
        expectSeq(8'h11, 8'h11, 4, 1);
        expDoneQ.push_back(1'b0);
        base = doneCount;
        applyStimulus(4);
        waitDone(base + 1);
        tick();
        checkOutput("postRstScoreboardEmpty", expQ.size(), 0);
        checkOutput("postRstIdle", descReady, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
